// File: rtl/jtframe_rom_rsp.sv
// CPU ROM responder: serves byte/half/word reads from a two-line cache of 32-bit SDRAM
// words and requests a refill from the SDRAM controller on a miss.
module jtframe_rom_rsp #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic          ok,
  output logic [DW-1:0] dout,
  output logic [AW-3:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          data_dst,
  input  logic          data_rdy,
  input  logic [31:0]   din
);

  localparam int unsigned TW = AW - 2;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e         state_q, state_d;
  logic [1:0]     valid_q;
  logic [TW-1:0]  tag_q [2];
  logic [31:0]    data_q [2];
  logic           ptr_q;

  logic           hit_q;
  logic [AW-1:0]  addr_l_q;
  logic [DW-1:0]  dout_q;
  logic           sdram_req_q, sdram_req_d;
  logic [TW-1:0]  sdram_addr_q, sdram_addr_d;

  logic [TW-1:0]  tag_in;
  logic           hit0, hit1, hit;
  logic [31:0]    hit_word;
  logic [DW-1:0]  lane;
  logic           fill;

  assign tag_in   = addr[AW-1:2];
  assign hit0     = valid_q[0] && (tag_q[0] == tag_in);
  assign hit1     = valid_q[1] && (tag_q[1] == tag_in);
  assign hit      = hit0 | hit1;
  assign hit_word = hit1 ? data_q[1] : data_q[0];

  // Little-endian lane extraction from the hit word
  if (DW == 8) begin : g_lane8
    assign lane = hit_word[{addr[1:0], 3'b000} +: 8];
  end else if (DW == 16) begin : g_lane16
    assign lane = hit_word[{addr[1], 4'b0000} +: 16];
  end else begin : g_lane32
    assign lane = hit_word;
  end

  // ok falls combinationally as soon as addr moves away from the latched one or cs drops
  assign ok         = hit_q & cs & (addr == addr_l_q);
  assign dout       = dout_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

  always_comb begin
    state_d      = state_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    fill         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs && !hit && !clr) begin
          state_d      = StReq;
          sdram_req_d  = 1'b1;
          sdram_addr_d = tag_in;
        end
      end
      StReq: begin
        if (sdram_ack) begin
          state_d     = StWait;
          sdram_req_d = 1'b0;
        end
      end
      StWait: begin
        if (data_rdy && data_dst) begin
          state_d = StIdle;
          // A refill landing together with clr is dropped and leaves the pointer alone
          fill    = !clr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (clr) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[ptr_q] <= 1'b1;
      tag_q[ptr_q]   <= sdram_addr_q;
      data_q[ptr_q]  <= din;
      ptr_q          <= ~ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q    <= 1'b0;
      addr_l_q <= '0;
      dout_q   <= '0;
    end else begin
      hit_q <= cs & hit & ~clr;
      if (cs && hit) begin
        addr_l_q <= addr;
        dout_q   <= lane;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_rom_rsp.sv
// Scoreboard bench for jtframe_rom_rsp: a CPU driver, an SDRAM responder backed by a ROM
// array, and a FIFO-of-words cache model that predicts hits and refill counts.
module tb_jtframe_rom_rsp;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr;
  logic          clr_cpu = 1'b0;
  logic          clr_rsp = 1'b0;
  logic          cs = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          ok;
  logic [DW-1:0] dout;
  logic [AW-3:0] sdram_addr;
  logic          sdram_req;
  logic          sdram_ack;
  logic          data_dst;
  logic          data_rdy;
  logic [31:0]   din;

  assign clr = clr_cpu | clr_rsp;

  jtframe_rom_rsp #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .cs         (cs),
    .addr       (addr),
    .ok         (ok),
    .dout       (dout),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .data_dst   (data_dst),
    .data_rdy   (data_rdy),
    .din        (din)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   rom [16];
  int unsigned   cache_m [$];
  logic [7:0]    exp_q [$];

  int            ack_dly = 0;
  int            rdy_dly = 0;
  int            nodst_n = 0;
  bit            clr_with_rdy = 1'b0;
  int            nreq = 0;
  int            nfill = 0;
  bit            in_wait = 1'b0;
  logic [AW-3:0] req_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit model_hit(input int unsigned w);
    foreach (cache_m[i]) if (cache_m[i] == w) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
    logic [31:0] t;
    t = rom[a[5:2]] >> (8 * int'(a[1:0]));
    return t[7:0];
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (ok && exp_q.size() > 0) check("dout", 32'(dout), 32'(exp_q.pop_front()));
  end

  // SDRAM responder
  initial begin : rsp
    logic [AW-3:0] w;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_dst  = 1'b0;
    din       = '0;
    forever begin
      @(negedge clk);
      if (rst_n && sdram_req) begin
        nreq++;
        w = sdram_addr;
        check("req_addr", 32'(sdram_addr), 32'(req_word));
        repeat (ack_dly) @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        check("req_drop", 32'(sdram_req), 32'd0);
        in_wait = 1'b1;
        repeat (rdy_dly) @(negedge clk);
        for (int i = 0; i < nodst_n; i++) begin
          data_rdy = 1'b1;
          data_dst = 1'b0;
          din      = ~rom[w[3:0]];
          @(negedge clk);
          if (i > 0) check("nodst_ok", 32'(ok), 32'd0);
        end
        data_rdy = 1'b1;
        data_dst = 1'b1;
        din      = rom[w[3:0]];
        if (clr_with_rdy) clr_rsp = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
        data_dst = 1'b0;
        din      = $urandom;
        if (clr_with_rdy) begin
          clr_rsp      = 1'b0;
          clr_with_rdy = 1'b0;
          cache_m.delete();
        end else begin
          cache_m.push_back(int'(w));
          if (cache_m.size() > 2) void'(cache_m.pop_front());
        end
        nfill++;
        in_wait = 1'b0;
      end
    end
  end

  // One CPU access; exp_reqs is the number of refills the model predicts before ok
  task automatic access(input logic [AW-1:0] a, input bit keep, input int exp_reqs);
    int k;
    int r0;
    r0 = nreq;
    if (!keep) begin
      @(posedge clk); #1;
      cs = 1'b0;
    end
    @(posedge clk); #1;
    req_word = a[AW-1:2];
    cs       = 1'b1;
    addr     = a;
    exp_q.push_back(exp_byte(a));
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      check("ok_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end else if (exp_reqs == 0) begin
      check("hit_latency", 32'(k), 32'd2);
    end
    check("req_count", 32'(nreq - r0), 32'(exp_reqs));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [AW-1:0] a;
    int            k;
    int            f0;
    int            e;
    rom[0] = 32'h4433_2211;
    for (int i = 1; i < 16; i++) rom[i] = $urandom;

    repeat (3) @(negedge clk);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First miss, then a byte step within the same word
    ack_dly = 3;
    rdy_dly = 2;
    access(18'h00001, 1'b1, 1);
    access(18'h00002, 1'b1, 0);

    // Fill words 1 and 2; word 0 gets evicted, word 2 stays
    ack_dly = 0;
    rdy_dly = 0;
    access(18'h00004, 1'b0, 1);
    access(18'h00008, 1'b0, 1);
    access(18'h00000, 1'b0, 1);
    access(18'h00009, 1'b0, 0);

    // cs dropped during WAIT: fill still lands, return is a hit
    rdy_dly = 8;
    @(posedge clk); #1;
    cs = 1'b0;
    @(posedge clk); #1;
    req_word = 16'd5;
    cs       = 1'b1;
    addr     = 18'd20;
    f0       = nfill;
    k        = 0;
    while (!in_wait && k < 50) begin @(negedge clk); k++; end
    check("wait_reached", 32'(in_wait), 32'd1);
    @(posedge clk); #1;
    cs = 1'b0;
    k  = 0;
    while (nfill == f0 && k < 50) begin @(negedge clk); k++; end
    check("drop_fill", 32'(nfill - f0), 32'd1);
    check("drop_ok", 32'(ok), 32'd0);
    repeat (2) @(posedge clk);
    rdy_dly = 1;
    access(18'd21, 1'b1, 0);

    // Refill coincident with clr is discarded: a second request follows
    clr_with_rdy = 1'b1;
    access(18'd24, 1'b0, 2);
    access(18'd22, 1'b0, 1);

    // data_rdy without data_dst is ignored
    nodst_n = 3;
    access(18'd28, 1'b0, 1);
    nodst_n = 0;

    // clr while holding a hit drops ok the following cycle
    access(18'd29, 1'b1, 0);
    @(posedge clk); #1;
    clr_cpu = 1'b1;
    @(negedge clk);
    check("pre_clr_ok", 32'(ok), 32'd1);
    @(posedge clk); #1;
    clr_cpu = 1'b0;
    cache_m.delete();
    @(negedge clk);
    check("clr_ok", 32'(ok), 32'd0);
    access(18'd29, 1'b1, 1);

    // Randomized accesses against the model
    for (int n = 0; n < 200; n++) begin
      a       = '0;
      a[5:2]  = 4'($urandom_range(0, 5) + (($urandom_range(0, 7) == 0) ? 10 : 0));
      a[1:0]  = 2'($urandom_range(0, 3));
      ack_dly = $urandom_range(0, 4);
      rdy_dly = $urandom_range(0, 4);
      nodst_n = $urandom_range(0, 2);
      e       = model_hit(int'(a[AW-1:2])) ? 0 : 1;
      if (e == 1 && $urandom_range(0, 9) == 0) begin
        clr_with_rdy = 1'b1;
        e = 2;
      end
      access(a, ($urandom_range(0, 1) == 1) && (a != addr), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_rom_rsp.md
Name: jtframe_rom_rsp

Overview:
- Slave-side responder for the CPU ROM handshake (`rom_cs`/`rom_ok`) used by the CPU wait/cen-gating logic.
- Takes a byte/word ROM address from the CPU, serves it from a two-line cache of 32-bit SDRAM words, and requests a refill from the SDRAM controller on a miss.
- Holds `ok` low until valid data is presented; the CPU side's wait logic stretches or recovers cycles accordingly.

Parameters:
- AW, 18, CPU ROM byte address width; must be >= 3.
- DW, 8, CPU data width: 8, 16 or 32 only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  invalidates both cache lines (ROM reload)
- cs  in  1  CPU ROM chip select
- addr  in  AW  CPU byte address
- ok  out  1  data valid for the current `addr`
- dout  out  DW  ROM data to CPU
- sdram_addr  out  AW-2  32-bit word address to SDRAM (`addr[AW-1:2]`)
- sdram_req  out  1  refill request
- sdram_ack  in  1  SDRAM controller accepted the request
- data_dst  in  1  SDRAM data bus is addressed to this slot
- data_rdy  in  1  SDRAM data valid strobe
- din  in  32  SDRAM read data, little-endian

Behaviour:
- Reset (async, `rst_n` low):
  - `ok`=0, `dout`=0, `sdram_req`=0, `sdram_addr`=0.
  - Both lines invalid, replace pointer=0, FSM in IDLE.
- Cache:
  - Two lines; each line holds valid, tag (`addr[AW-1:2]`, AW-2 bits) and data[31:0].
  - Hit means the line is valid and its tag equals `addr[AW-1:2]`.
- Lane select (little-endian):
  - DW=8: byte `addr[1:0]` (0 -> `din[7:0]`).
  - DW=16: half `addr[1]`.
  - DW=32: full word.
- `ok` generation:
  - A registered flag `hit_r` is set on every clk where `cs` is high and there is a hit. The same edge latches `dout` from the hit line and latches `addr` into `addr_l`.
  - `ok = hit_r & cs & (addr == addr_l)`. It drops in the same cycle that `addr` changes or `cs` falls.
  - Minimum hit latency: `ok` is high 1 clk after `cs` rises on a cached address.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ: when `cs` is high, there is no hit, and `clr` is low. Capture `sdram_addr <= addr[AW-1:2]` and assert `sdram_req`.
  - REQ -> WAIT: on `sdram_ack`. `sdram_req` stays high until the cycle `sdram_ack` is seen, then drops the next clk. `sdram_addr` is held constant throughout REQ and WAIT.
  - WAIT -> IDLE: on `data_rdy & data_dst`.
    - Write `din` and the tag into the line at the replace pointer, set it valid, and toggle the pointer.
    - Hit is evaluated from the next clk, so a miss is served with `ok` at the earliest 2 clk after `data_rdy`.
- Boundary cases:
  - `data_rdy` without `data_dst` is ignored. `data_rdy`/`data_dst` outside WAIT are ignored. `sdram_ack` outside REQ is ignored.
  - `cs` falls or `addr` changes during REQ/WAIT: the transaction is not aborted. The line is filled on arrival, and `ok` stays 0 until a fresh hit.
  - `clr` high:
    - All valid bits clear, `hit_r` clears, and `ok` drops next clk.
    - A refill completing on the same clk as `clr` is discarded (line stays invalid) and the pointer is not toggled.
    - `clr` during REQ/WAIT does not cancel the request.
  - No new request is issued while `clr` is high.
  - Both lines hit the same tag: cannot occur, because a fill only happens on a miss.
  - Reset mid-transaction returns to IDLE immediately with `sdram_req`=0. An SDRAM response arriving after reset is ignored (FSM not in WAIT).

Test Plan:
- Reset, then `cs`=1, `addr`=0x00001 (DW=8) -> `sdram_req`=1 with `sdram_addr`=0 the next clk. Ack after 3 clk, then `din`=0x44332211 with `data_rdy`&`data_dst` -> 2 clk later `ok`=1, `dout`=0x22.
- Following the first test, step `addr` 0x00002 -> `ok` drops the same cycle and is 1 one clk later with `dout`=0x33; no `sdram_req`.
- Fill word 0, fill word 1, then access word 2 -> line 0 is replaced (pointer wrap). Access word 0 -> miss with new `sdram_req`. Access word 2 -> hit.
- Drop `cs` during WAIT, then return to the same address after `data_rdy` -> no second request, `ok`=1 one clk after `cs`.
- `clr` coincident with `data_rdy`&`data_dst` -> line stays invalid, and the next access to that address issues `sdram_req`.
- `data_rdy`=1 with `data_dst`=0 in WAIT -> no fill, `ok` stays 0. Then `data_dst`=1 -> fill completes.
